// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared loader types and constants
package cpu_pkg;

   typedef enum logic [2:0] {
      LST_IDLE   = 3'd0,
      LST_CNT_LO = 3'd1,
      LST_CNT_HI = 3'd2,
      LST_DATA   = 3'd3,
      LST_CHECK  = 3'd4
   } loader_state_e;

   localparam logic [7:0] LOADER_SYNC = 8'hA5;

   localparam logic [1:0] LERR_NONE = 2'd0;
   localparam logic [1:0] LERR_CHK  = 2'd1;
   localparam logic [1:0] LERR_OVF  = 2'd2;
   localparam logic [1:0] LERR_TMO  = 2'd3;

endpackage

// File: rtl/loader_wdog.sv
// rtl/loader_wdog.sv - inter-byte idle watchdog for the loader
module loader_wdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // Fires on the edge that would complete TIMEOUT idle cycles, so the abort lands at t+TIMEOUT.
   assign expired = en && !clr && (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || !en) begin
         cnt <= '0;
      end else if (cnt != LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing 32-bit words into imem
module imem_loader
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [1:0]        err_code
);

   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

   loader_state_e state;
   logic [7:0]    cnt_lo;
   logic [15:0]   word_cnt;
   logic [15:0]   word_idx;
   logic [1:0]    byte_idx;
   logic [23:0]   word_buf;
   logic [7:0]    chk;

   logic          accept;
   logic          tmo_expired;
   logic [15:0]   frame_n;
   logic          last_word;

   assign accept    = in_valid && in_ready;
   assign frame_n   = {in_data, cnt_lo};
   assign last_word = (word_idx == word_cnt - 16'd1);

   loader_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .en      (state != LST_IDLE),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LST_IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         err_code  <= LERR_NONE;
         cnt_lo    <= '0;
         word_cnt  <= '0;
         word_idx  <= '0;
         byte_idx  <= '0;
         word_buf  <= '0;
         chk       <= '0;
      end else begin
         in_ready  <= 1'b1;
         mem_we    <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;

         // Aborts leave cpu_hold set: only a verified frame may release the CPU.
         if (tmo_expired) begin
            load_err <= 1'b1;
            err_code <= LERR_TMO;
            state    <= LST_IDLE;
         end else if (accept) begin
            case (state)
               LST_IDLE: begin
                  if (in_data == LOADER_SYNC) begin
                     state    <= LST_CNT_LO;
                     byte_idx <= '0;
                     word_idx <= '0;
                     chk      <= '0;
                     cpu_hold <= 1'b1;
                  end
               end
               LST_CNT_LO: begin
                  cnt_lo <= in_data;
                  state  <= LST_CNT_HI;
               end
               LST_CNT_HI: begin
                  if ({1'b0, frame_n} > CAPACITY) begin
                     load_err <= 1'b1;
                     err_code <= LERR_OVF;
                     state    <= LST_IDLE;
                  end else if (frame_n == 16'd0) begin
                     state <= LST_CHECK;
                  end else begin
                     word_cnt <= frame_n;
                     state    <= LST_DATA;
                  end
               end
               LST_DATA: begin
                  chk      <= chk ^ in_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_buf[7:0]   <= in_data;
                     2'd1: word_buf[15:8]  <= in_data;
                     2'd2: word_buf[23:16] <= in_data;
                     default: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx[ADDR_W-1:0];
                        mem_wdata <= {in_data, word_buf};
                        word_idx  <= word_idx + 16'd1;
                        if (last_word) state <= LST_CHECK;
                     end
                  endcase
               end
               LST_CHECK: begin
                  state <= LST_IDLE;
                  if (in_data == chk) begin
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                     err_code  <= LERR_NONE;
                  end else begin
                     load_err <= 1'b1;
                     err_code <= LERR_CHK;
                  end
               end
               default: state <= LST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

   localparam int ADDR_W  = 4;
   localparam int TIMEOUT = 20;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic [1:0]        err_code;

   int total = 0;
   int bad   = 0;

   logic [35:0] wr_q[$];   // {addr, data}
   logic [3:0]  ev_q[$];   // {is_err, code, hold}
   logic [7:0]  frame[$];

   imem_loader #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] ev(input bit is_err, input logic [1:0] code, input bit hold);
      return {is_err, code, hold};
   endfunction

   // Monitor: pops expectations whenever the DUT presents a write or a completion pulse.
   always @(negedge clk) begin
      logic [35:0] w;
      logic [3:0]  e;
      if (mem_we) begin
         if (wr_q.size() == 0) begin
            check("unexpected_we", 32'(mem_we), 32'd0);
         end else begin
            w = wr_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(w[35:32]));
            check("wr_data", mem_wdata, w[31:0]);
         end
      end
      if (load_done || load_err) begin
         if (ev_q.size() == 0) begin
            check("unexpected_event", 32'({load_done, load_err}), 32'd0);
         end else begin
            e = ev_q.pop_front();
            check("ev_done", 32'(load_done), 32'(!e[3]));
            check("ev_err",  32'(load_err),  32'(e[3]));
            check("ev_code", 32'(err_code),  32'(e[2:1]));
            check("ev_hold", 32'(cpu_hold),  32'(e[0]));
         end
      end
   end

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame();
      foreach (frame[i]) send(frame[i]);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < TIMEOUT + 8; i++) begin
         if (wr_q.size() == 0 && ev_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      repeat (3) @(posedge clk);
      #1;
      check({"drain_", nm}, 32'(wr_q.size() + ev_q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0]  b;
      logic [7:0]  x;
      logic [31:0] w;
      int          lat;

      #3;
      check("reset_outputs", 32'({in_ready, mem_we, mem_addr, cpu_hold, load_done, load_err, err_code}), 32'd0);
      check("reset_wdata", mem_wdata, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_reset", 32'(in_ready), 32'd1);

      // normal load, checksum 13^93^10 = 90
      wr_q.push_back({4'd0, 32'h00000013});
      wr_q.push_back({4'd1, 32'h00100093});
      ev_q.push_back(ev(0, 2'd0, 0));
      send(8'hA5);
      check("hold_on_sync", 32'(cpu_hold), 32'd1);
      frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      send_frame();
      drain("normal");
      check("normal_hold_released", 32'(cpu_hold), 32'd0);

      // bad checksum
      wr_q.push_back({4'd0, 32'h00000013});
      wr_q.push_back({4'd1, 32'h00100093});
      ev_q.push_back(ev(1, 2'd1, 1));
      frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h04};
      send_frame();
      drain("badchk");
      check("badchk_code_sticky", 32'(err_code), 32'd1);
      check("badchk_hold_kept", 32'(cpu_hold), 32'd1);

      // overflow: 17 words into a 16-word memory
      ev_q.push_back(ev(1, 2'd2, 1));
      frame = '{8'hA5, 8'h11, 8'h00};
      send_frame();
      drain("overflow");

      // exactly full capacity: 16 words, addresses 0..15
      frame = '{8'hA5, 8'h10, 8'h00};
      x = 8'h00;
      for (int k = 0; k < 16; k++) begin
         w = '0;
         for (int j = 0; j < 4; j++) begin
            b = 8'(k * 7 + j * 3 + 1);
            frame.push_back(b);
            w[8*j +: 8] = b;
            x ^= b;
         end
         wr_q.push_back({4'(k), w});
      end
      frame.push_back(x);
      ev_q.push_back(ev(0, 2'd0, 0));
      send_frame();
      drain("full");

      // zero-length frame
      ev_q.push_back(ev(0, 2'd0, 0));
      frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame();
      drain("zero_len");

      // leading garbage, sync value inside payload, chk = A5^11^22^33 = A5
      wr_q.push_back({4'd0, 32'h332211A5});
      ev_q.push_back(ev(0, 2'd0, 0));
      frame = '{8'h55, 8'hA5, 8'h01, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5};
      send_frame();
      drain("garbage_sync_data");

      // timeout after a partial word
      ev_q.push_back(ev(1, 2'd3, 1));
      frame = '{8'hA5, 8'h01, 8'h00, 8'h13};
      send_frame();
      lat = 0;
      for (int c = 1; c <= TIMEOUT + 5; c++) begin
         @(posedge clk);
         #1;
         if (load_err) begin
            lat = c;
            break;
         end
      end
      check("tmo_latency", 32'(lat), 32'(TIMEOUT));
      drain("timeout");

      // gap just under the limit is tolerated; frame recovers after timeout
      wr_q.push_back({4'd0, 32'h13000000});
      ev_q.push_back(ev(0, 2'd0, 0));
      frame = '{8'hA5, 8'h01, 8'h00, 8'h00};
      send_frame();
      repeat (TIMEOUT - 2) @(posedge clk);
      #1;
      frame = '{8'h00, 8'h00, 8'h13, 8'h13};
      send_frame();
      drain("near_timeout");

      // reset between byte 2 and byte 3 of a word
      frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
      send_frame();
      #2;
      rst = 1'b0;
      #1;
      check("midreset_outputs", 32'({in_ready, mem_we, mem_addr, cpu_hold, load_done, load_err, err_code}), 32'd0);
      check("midreset_wdata", mem_wdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      frame = '{8'h00, 8'h00};
      send_frame();
      drain("midreset");
      check("midreset_hold", 32'(cpu_hold), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
